// File: rtl/seq_detect_prog.sv
// seq_detect_prog: programmable serial pattern detector; the match counter exists only when SEQDET_CNT_EN is defined
module seq_detect_prog #(
  parameter int MAX_LEN = 8,
  parameter logic [MAX_LEN-1:0] DEF_PAT = MAX_LEN'('b0010_1101),
  parameter int DEF_LEN = 6,
  parameter int CNT_W = 8,
  localparam int LW = $clog2(MAX_LEN) + 1
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               x,
  input  logic               ovl,
  input  logic               load,
  input  logic [MAX_LEN-1:0] pat_in,
  input  logic [LW-1:0]      len_in,
  output logic               y,
  output logic [CNT_W-1:0]   match_cnt
);
  logic [MAX_LEN-1:0] pat_q, pat_d, win, mask;
  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [LW-1:0]      len_q, len_d, fill_q, fill_d, len_c;
  logic               full;
  // match window is history plus the live bit; fill gates it until len-1 fresh bits are held
  always_comb begin
    win    = {hist_q, x};
    mask   = {MAX_LEN{1'b1}} >> (LW'(MAX_LEN) - len_q);
    full   = fill_q == len_q - LW'(1);
    y      = rst & en & ~load & full & (((win ^ pat_q) & mask) == '0);
    len_c  = (len_in == '0) ? LW'(1) : (len_in > LW'(MAX_LEN)) ? LW'(MAX_LEN) : len_in;
    pat_d  = load ? pat_in : pat_q;
    len_d  = load ? len_c : len_q;
    hist_d = (en & ~load) ? win[MAX_LEN-2:0] : hist_q;
    fill_d = load ? '0 : ~en ? fill_q : (y & ~ovl) ? '0 : full ? fill_q : fill_q + LW'(1);
  end
  // detector state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_q  <= DEF_PAT;
      len_q  <= LW'(DEF_LEN);
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      pat_q  <= pat_d;
      len_q  <= len_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end
`ifdef SEQDET_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // saturating match count, cleared by a pattern load
  always_comb cnt_d = load ? '0 : (y && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
  // match counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign match_cnt = cnt_q;
`else
  assign match_cnt = '0;
`endif
endmodule

// File: tb/tb_seq_detect_prog.sv
// tb_seq_detect_prog: randomized and directed checks of seq_detect_prog against a bit-history model
module tb_seq_detect_prog;
  logic clk = 0, rst = 0, en = 0, x = 0, ovl = 0, load = 0;
  logic [7:0] pat_in = 0;
  logic [3:0] len_in = 0;
  logic y, y2;
  logic [7:0] match_cnt;
  logic [1:0] match_cnt2;
  int n_chk = 0, n_err = 0;
  logic [7:0] m_pat;
  int m_len, m_fresh, m_cnt8, m_cnt2;
  bit m_bits[$];
  logic yo;

  seq_detect_prog dut (.clk(clk), .rst(rst), .en(en), .x(x), .ovl(ovl), .load(load),
    .pat_in(pat_in), .len_in(len_in), .y(y), .match_cnt(match_cnt));
  seq_detect_prog #(.CNT_W(2)) dut2 (.clk(clk), .rst(rst), .en(en), .x(x), .ovl(ovl), .load(load),
    .pat_in(pat_in), .len_in(len_in), .y(y2), .match_cnt(match_cnt2));

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp_v);
    n_chk++;
    if (obs != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic int cnt_en(input int c);
`ifdef SEQDET_CNT_EN
    return c;
`else
    return 0;
`endif
  endfunction

  function automatic void model_reset();
    m_pat = 8'b0010_1101;
    m_len = 6;
    m_fresh = 0;
    m_cnt8 = 0;
    m_cnt2 = 0;
    m_bits.delete();
  endfunction

  // a match needs len-1 fresh earlier bits; bit k back in time must equal pat[k]
  function automatic bit model_y();
    if (!rst || !en || load || m_fresh < m_len - 1) return 0;
    if (x != m_pat[0]) return 0;
    for (int k = 1; k < m_len; k++)
      if (m_bits[m_bits.size() - k] != m_pat[k]) return 0;
    return 1;
  endfunction

  function automatic void model_step(input bit yv);
    if (load) begin
      m_pat = pat_in;
      m_len = (len_in == 0) ? 1 : (len_in > 8) ? 8 : int'(len_in);
      m_fresh = 0;
      m_cnt8 = 0;
      m_cnt2 = 0;
    end else if (en) begin
      m_bits.push_back(x);
      if (m_bits.size() > 16) void'(m_bits.pop_front());
      m_fresh = (yv && !ovl) ? 0 : m_fresh + 1;
      if (yv && m_cnt8 < 255) m_cnt8++;
      if (yv && m_cnt2 < 3) m_cnt2++;
    end
  endfunction

  task automatic cyc(input logic e, input logic xi, input logic o, input logic l,
                     input logic [7:0] p, input logic [3:0] li, output logic yv);
    bit ey;
    en = e; x = xi; ovl = o; load = l; pat_in = p; len_in = li;
    #2;
    ey = model_y();
    check("y", y, ey);
    check("y_cw2", y2, ey);
    yv = y;
    @(posedge clk);
    model_step(ey);
    #1;
    check("cnt", match_cnt, cnt_en(m_cnt8));
    check("cnt_cw2", match_cnt2, cnt_en(m_cnt2));
  endtask

  task automatic do_reset();
    rst = 0;
    model_reset();
    #2;
    check("rst_y", y, 0);
    check("rst_cnt", match_cnt, 0);
    check("rst_cnt_cw2", match_cnt2, 0);
    @(posedge clk);
    #1 rst = 1;
  endtask

  task automatic stream(input logic o, input int n, input logic [15:0] bits, input logic [15:0] ys, input string tag);
    for (int i = n - 1; i >= 0; i--) begin
      cyc(1, bits[i], o, 0, 0, 0, yo);
      check(tag, yo, ys[i]);
    end
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    do_reset();
    // default pattern, overlapping
    stream(1, 9, 16'b101101101, 16'b000001001, "ovl_y");
    check("ovl_cnt", match_cnt, cnt_en(2));
    // default pattern, non-overlapping
    do_reset();
    stream(0, 9, 16'b101101101, 16'b000001000, "novl_y");
    check("novl_cnt", match_cnt, cnt_en(1));
    // load 0011 and stall mid-stream
    cyc(1, 1, 1, 1, 8'b0011, 4, yo);
    check("load_y", yo, 0);
    check("load_cnt", match_cnt, 0);
    stream(1, 3, 16'b001, 16'b000, "gap_y");
    cyc(0, 1, 1, 0, 0, 0, yo);
    check("gap_hold_y", yo, 0);
    cyc(0, 0, 1, 0, 0, 0, yo);
    check("gap_hold_y", yo, 0);
    stream(1, 1, 16'b1, 16'b1, "gap_y");
    // length clamping
    cyc(1, 0, 1, 1, 8'h01, 0, yo);
    stream(1, 3, 16'b101, 16'b101, "len0_y");
    cyc(1, 0, 1, 1, 8'b10110011, 15, yo);
    stream(1, 8, 16'b10110011, 16'b00000001, "len15_y");
    // reset mid-sequence discards partial match
    do_reset();
    stream(1, 5, 16'b10110, 16'b00000, "pre_rst_y");
    #3 rst = 0;
    model_reset();
    #1;
    check("async_rst_y", y, 0);
    check("async_rst_cnt", match_cnt, 0);
    @(posedge clk);
    #1 rst = 1;
    stream(1, 7, 16'b1101101, 16'b0000001, "post_rst_y");
    // saturation of the narrow counter
    cyc(1, 0, 1, 1, 8'b11, 2, yo);
    stream(1, 5, 16'b11111, 16'b01111, "sat_y");
    check("sat_cnt_cw2", match_cnt2, cnt_en(3));
    check("sat_cnt", match_cnt, cnt_en(4));
    // random traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else cyc($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom_range(0, 3) != 0),
               $urandom_range(0, 39) == 0, 8'($urandom), 4'($urandom_range(0, 15)), yo);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/seq_detect_prog.md
SEQ_DETECT_PROG -- requirements
Module: seq_detect_prog

Interface
REQ-001 Parameter MAX_LEN, default 8, maximum pattern length in bits, legal range 2..16, SHALL be supported.
REQ-002 Parameter DEF_PAT, default 8'b0010_1101, reset pattern (MAX_LEN bits), SHALL be supported.
REQ-003 Parameter DEF_LEN, default 6, reset pattern length, SHALL be supported.
REQ-004 Parameter CNT_W, default 8, match counter width, SHALL be supported.
REQ-005 Port list SHALL be (LW = clog2(MAX_LEN)+1):
- clk, input, 1, clock; all state updates on the rising edge.
- rst, input, 1, asynchronous, active-low reset.
- en, input, 1, sample qualifier; x is consumed only when en=1.
- x, input, 1, serial data bit.
- ovl, input, 1, overlap mode: 1 = overlapping, 0 = non-overlapping.
- load, input, 1, pattern load strobe.
- pat_in, input, MAX_LEN, new pattern, right-aligned; the first-received bit is pat_in[len-1].
- len_in, input, LW, new pattern length.
- y, output, 1, Mealy match output.
- match_cnt, output, CNT_W, number of matches since reset or load.

Function
REQ-006 Internal state SHALL be: pattern register pat, length register len, history shift register hist (MAX_LEN-1 bits), and fill counter fill (0..len-1).
REQ-007 y SHALL be combinational from state and current inputs: y = en & ~load & (fill==len-1) & ({hist[len-2:0],x} == pat[len-1:0]).
REQ-008 On an en=1, load=0 edge, hist SHALL shift left with x entering at bit 0.
REQ-009 On an en=1, load=0 edge, fill SHALL increment, saturating at len-1.
REQ-010 When y=1 and ovl=1, fill SHALL stay at len-1, so overlapping matches are detected.
REQ-011 When y=1 and ovl=0, fill SHALL clear to 0, so the next match needs len fresh bits.
REQ-012 With en=0 and load=0, all state SHALL hold, and y SHALL be 0.
REQ-013 When load=1, pat and len SHALL be captured on the same edge and fill SHALL clear to 0.
- x is ignored on that edge.
- y=0 during that cycle.
- load has priority over en.
REQ-014 len_in=0 SHALL be treated as 1, and len_in>MAX_LEN SHALL be treated as MAX_LEN.
REQ-015 pat_in bits at or above len SHALL be ignored in comparison.
REQ-016 For len=1, y SHALL equal en & ~load & (x==pat[0]), with hist unused.
REQ-017 Latency: the match SHALL be flagged in the same cycle as the final pattern bit, with no register delay.
REQ-018 match_cnt SHALL increment on each edge where y=1, saturating at 2^CNT_W-1 (no wrap).
REQ-019 match_cnt SHALL clear on load.
REQ-020 A change to ovl SHALL take effect at the next match; no state is flushed.

Reset
REQ-021 On rst=0 the block SHALL immediately apply, independent of clk:
- pat = DEF_PAT
- len = DEF_LEN
- hist = 0
- fill = 0
- match_cnt = 0
REQ-022 y SHALL be 0 while rst=0.
REQ-023 Reset asserted mid-sequence SHALL discard partial matches; detection restarts from an empty history.

Configuration
REQ-024 Macro SEQDET_CNT_EN defined: match_cnt SHALL behave per REQ-018 and REQ-019.
REQ-025 Macro SEQDET_CNT_EN undefined: the counter SHALL be absent, match_cnt SHALL be tied to 0, and all other behaviour SHALL be unchanged.

Verification
REQ-026 The bench SHALL cover the following directed scenarios:
- Reset defaults (len=6, pat=101101), ovl=1, stream 101101101 -> y=1 on bits 6 and 9; match_cnt=2.
- Same stream with ovl=0 -> y=1 on bit 6 only; match_cnt=1.
- Load pat=0011, len=4, then stream 0011 with en low for 2 cycles mid-stream -> y=1 only on the final 1; the y=0 gap is held.
- len_in=0 with pat_in[0]=1, then stream 1,0,1 -> y=1,0,1; len_in=15 (MAX_LEN=8) -> behaves as len=8.
- rst pulsed after 10110 received, then 1 -> y=0; the next full 101101 is required before y=1.
- CNT_W=2, ovl=1, pattern 11 (len=2), stream of five 1s -> four matches; match_cnt saturates at 3; without SEQDET_CNT_EN, match_cnt=0 throughout.
